// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB3 master bridge with built-in six-slave decode,
// unmapped-address termination and an optional PREADY timeout.
module ahb_to_apb_bridge #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  output logic                  PENABLE,
  output logic                  PSEL0,
  output logic                  PSEL1,
  output logic                  PSEL2,
  output logic                  PSEL3,
  output logic                  PSEL4,
  output logic                  PSEL5,
  input  logic                  PREADY,
  input  logic [31:0]           PRDATA,
  input  logic                  PSLVERR
);

  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_t;

  state_t                r_state;
  logic                  r_hreadyout;
  logic                  r_hresp;
  logic [31:0]           r_hrdata;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [31:0]           r_pwdata;
  logic                  r_penable;
  logic [5:0]            r_psel;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:2] r_haddr;
  logic                  r_hwrite;
  logic                  r_mapped;
  logic [2:0]            r_idx;

  logic                  w_accept;
  logic                  w_mapped;
  logic [CW-1:0]         w_cnt_nxt;
  logic [2:0]            w_unused;

  assign w_accept  = HSEL & HTRANS[1] & HREADY;
  // Anything above bit 15 must be zero; index 6..15 has no slave behind it.
  assign w_mapped  = ((HADDR >> 16) == '0) && (HADDR[15:12] <= 4'd5);
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_unused  = {HTRANS[0], HADDR[1:0]};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_penable   <= 1'b0;
      r_psel      <= '0;
      r_cnt       <= '0;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_mapped    <= 1'b0;
      r_idx       <= '0;
    end else begin
      if (w_accept && (r_state == S_IDLE || r_state == S_ERR2)) begin
        r_haddr  <= HADDR[ADDR_WIDTH-1:2];
        r_hwrite <= HWRITE;
        r_mapped <= w_mapped;
        r_idx    <= HADDR[14:12];
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_hreadyout <= 1'b0;
            r_state     <= S_LATCH;
          end
        end
        S_LATCH: begin
          if (r_hwrite) r_pwdata <= HWDATA;
          if (r_mapped) begin
            r_paddr  <= {r_haddr, 2'b00};
            r_pwrite <= r_hwrite;
            r_psel   <= 6'b000001 << r_idx;
            r_cnt    <= '0;
            r_state  <= S_SETUP;
          end else begin
            r_hresp <= 1'b1;
            r_state <= S_ERR1;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            if (PSLVERR) begin
              r_hresp <= 1'b1;
              r_state <= S_ERR1;
            end else begin
              r_hreadyout <= 1'b1;
              if (!r_pwrite) r_hrdata <= PRDATA;
              r_state <= S_IDLE;
            end
          end else if (TIMEOUT != 0 && w_cnt_nxt == CW'(TIMEOUT)) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_hresp   <= 1'b1;
            r_state   <= S_ERR1;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_ERR1: begin
          r_hreadyout <= 1'b1;
          r_state     <= S_ERR2;
        end
        S_ERR2: begin
          r_hresp <= 1'b0;
          if (w_accept) begin
            r_hreadyout <= 1'b0;
            r_state     <= S_LATCH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign HRDATA    = r_hrdata;
  assign PADDR     = r_paddr;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;
  assign PENABLE   = r_penable;
  assign PSEL0     = r_psel[0];
  assign PSEL1     = r_psel[1];
  assign PSEL2     = r_psel[2];
  assign PSEL3     = r_psel[3];
  assign PSEL4     = r_psel[4];
  assign PSEL5     = r_psel[5];

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// Randomized bench for ahb_to_apb_bridge: a transaction-level model predicts
// every AHB/APB output cycle by cycle from address, direction, waits and error.
module tb_ahb_to_apb_bridge;

  localparam int unsigned AW = 20;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [AW-1:0] HADDR, PADDR;
  logic [1:0]    HTRANS;
  logic [31:0]   HWDATA, HRDATA, PWDATA, PRDATA;
  logic          PWRITE, PENABLE, PREADY, PSLVERR;
  logic          PSEL0, PSEL1, PSEL2, PSEL3, PSEL4, PSEL5;
  logic [5:0]    w_psel;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hrdata;

  always #5 clk = ~clk;

  assign HREADY = HREADYOUT;
  assign w_psel = {PSEL5, PSEL4, PSEL3, PSEL2, PSEL1, PSEL0};

  ahb_to_apb_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .HCLK(clk), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL0(PSEL0), .PSEL1(PSEL1),
    .PSEL2(PSEL2), .PSEL3(PSEL3), .PSEL4(PSEL4), .PSEL5(PSEL5),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"},    32'(HREADYOUT), 32'd1);
    check({tag, "_resp"},   32'(HRESP),     32'd0);
    check({tag, "_hrdata"}, HRDATA,         32'd0);
    check({tag, "_paddr"},  32'(PADDR),     32'd0);
    check({tag, "_pwrite"}, 32'(PWRITE),    32'd0);
    check({tag, "_pwdata"}, PWDATA,         32'd0);
    check({tag, "_pen"},    32'(PENABLE),   32'd0);
    check({tag, "_psel"},   32'(w_psel),    32'd0);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      step();
      check("idle_rdy",  32'(HREADYOUT), 32'd1);
      check("idle_resp", 32'(HRESP),     32'd0);
      check("idle_psel", 32'(w_psel),    32'd0);
      check("idle_pen",  32'(PENABLE),   32'd0);
      check("idle_hrd",  HRDATA,         m_hrdata);
    end
  endtask

  // Entered in a cycle where the bridge is expected ready; returns in the
  // completing cycle (IDLE-ready or ERR2) so a following call is back-to-back.
  task automatic do_txn(input logic [AW-1:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int unsigned waits, input logic err);
    logic        mapped;
    logic        fail;
    logic [5:0]  exp_sel;
    int unsigned n_acc;
    mapped  = (addr[AW-1:16] == '0) && (addr[15:12] <= 4'd5);
    exp_sel = mapped ? (6'b000001 << addr[14:12]) : 6'b000000;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr;
    step();
    HSEL = 1'($urandom); HTRANS = 2'b00; HADDR = AW'($urandom);
    HWRITE = 1'($urandom); HWDATA = wdata;
    check("latch_rdy",  32'(HREADYOUT), 32'd0);
    check("latch_resp", 32'(HRESP),     32'd0);
    check("latch_psel", 32'(w_psel),    32'd0);
    if (mapped) begin
      step();
      HWDATA = $urandom;
      check("setup_psel",  32'(w_psel),    32'(exp_sel));
      check("setup_pen",   32'(PENABLE),   32'd0);
      check("setup_paddr", 32'(PADDR),     32'(addr & ~AW'(3)));
      check("setup_pwr",   32'(PWRITE),    32'(wr));
      check("setup_rdy",   32'(HREADYOUT), 32'd0);
      if (wr) check("setup_pwdata", PWDATA, wdata);
      if (TO != 0 && waits >= TO) begin
        n_acc = TO;
        fail  = 1'b1;
      end else begin
        n_acc = waits + 1;
        fail  = err;
      end
      for (int unsigned k = 0; k < n_acc; k++) begin
        step();
        PREADY  = (k == waits);
        PSLVERR = err && (k == waits);
        PRDATA  = rdata;
        check("acc_psel",  32'(w_psel),    32'(exp_sel));
        check("acc_pen",   32'(PENABLE),   32'd1);
        check("acc_rdy",   32'(HREADYOUT), 32'd0);
        check("acc_paddr", 32'(PADDR),     32'(addr & ~AW'(3)));
        check("acc_pwr",   32'(PWRITE),    32'(wr));
      end
      step();
      PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
    end else begin
      fail = 1'b1;
      step();
    end
    if (!fail) begin
      if (!wr) m_hrdata = rdata;
      check("done_rdy",  32'(HREADYOUT), 32'd1);
      check("done_resp", 32'(HRESP),     32'd0);
      check("done_psel", 32'(w_psel),    32'd0);
      check("done_pen",  32'(PENABLE),   32'd0);
      check("done_hrd",  HRDATA,         m_hrdata);
    end else begin
      check("err1_rdy",  32'(HREADYOUT), 32'd0);
      check("err1_resp", 32'(HRESP),     32'd1);
      check("err1_psel", 32'(w_psel),    32'd0);
      check("err1_pen",  32'(PENABLE),   32'd0);
      check("err1_hrd",  HRDATA,         m_hrdata);
      step();
      check("err2_rdy",  32'(HREADYOUT), 32'd1);
      check("err2_resp", 32'(HRESP),     32'd1);
      check("err2_psel", 32'(w_psel),    32'd0);
      check("err2_hrd",  HRDATA,         m_hrdata);
    end
  endtask

  initial begin
    logic [3:0]  hi;
    logic [3:0]  idx;
    logic [11:0] low;
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HWDATA = '0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    m_hrdata = '0;
    step();
    step();
    HRESET = 1'b0;
    check_reset_vals("rst");
    idle(1);

    do_txn(20'h01004, 1'b1, 32'hDEADBEEF, 32'h0, 0, 1'b0);
    idle(1);
    do_txn(20'h05000, 1'b0, 32'h0, 32'h12345678, 2, 1'b0);
    idle(1);
    do_txn(20'h07000, 1'b0, 32'h0, 32'hAAAA5555, 0, 1'b0);
    idle(1);
    do_txn(20'h12000, 1'b0, 32'h0, 32'hBBBB0000, 0, 1'b0);
    do_txn(20'h02000, 1'b1, 32'hCAFEF00D, 32'h0, 1, 1'b1);
    do_txn(20'h03000, 1'b0, 32'h0, 32'h0BADC0DE, 0, 1'b0);
    idle(1);
    do_txn(20'h00000, 1'b0, 32'h0, 32'h11111111, 10, 1'b0);
    do_txn(20'h00008, 1'b0, 32'h0, 32'h22222222, 3, 1'b0);
    idle(2);

    for (int i = 0; i < 60; i++) begin
      hi  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      idx = 4'($urandom_range(0, 9));
      low = 12'($urandom);
      do_txn({hi, idx, low}, 1'($urandom), $urandom, $urandom,
             $urandom_range(0, 6), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 20'h00000; HWRITE = 1'b0;
    step();
    HSEL = 1'b0; HTRANS = 2'b00;
    step();
    PREADY = 1'b0; PSLVERR = 1'b0;
    step();
    check("pre_rst_pen", 32'(PENABLE), 32'd1);
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    m_hrdata = '0;
    check_reset_vals("mid_rst");
    idle(2);
    do_txn(20'h04000, 1'b0, 32'h0, 32'h44440000, 1, 1'b0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
